// File: rtl/arf_stack_fetch_ctrl_if.sv
// rtl/arf_stack_fetch_ctrl_if.sv - command handshake and result bundle for the ARF sequencer
interface arf_stack_fetch_ctrl_if;
    logic [1:0]  cmd;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [15:0] data_in;
    logic [15:0] result;
    logic        done;

    modport master (
        output cmd, cmd_valid, data_in,
        input  cmd_ready, result, done
    );

    modport slave (
        input  cmd, cmd_valid, data_in,
        output cmd_ready, result, done
    );
endinterface

// File: rtl/arf_stack_fetch_ctrl.sv
// rtl/arf_stack_fetch_ctrl.sv - sequences fetch/push/pop/jump byte transfers over the ARF and memory
module arf_stack_fetch_ctrl (
    input  logic                        clk_i,
    input  logic                        rst_i,
    arf_stack_fetch_ctrl_if.slave       cmd_if,
    input  logic [7:0]                  mem_out_i,
    output logic [15:0]                 arf_i_o,
    output logic [1:0]                  arf_funsel_o,
    output logic [2:0]                  arf_regsel_o,
    output logic [1:0]                  arf_outdsel_o,
    output logic                        mem_cs_o,
    output logic                        mem_wr_o,
    output logic [7:0]                  mem_data_o
);

    typedef enum logic [3:0] {
        IDLE, F_LO, F_HI, PU_DEC, PU_HI, PU_LO, PO_LO, PO_HI, JMP
    } state_t;

    localparam logic [1:0] FS_DEC  = 2'b00;
    localparam logic [1:0] FS_INC  = 2'b01;
    localparam logic [1:0] FS_LOAD = 2'b10;
    localparam logic [2:0] SEL_PC  = 3'b100;
    localparam logic [2:0] SEL_SP  = 3'b010;

    state_t      state_q, state_d;
    logic [1:0]  cmd_q, cmd_d;
    logic [15:0] data_q, data_d;
    logic [15:0] result_q, result_d;
    logic        done_q, done_d;
    logic [2:0]  regsel_raw;
    logic        cs_raw, wr_raw;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            cmd_q    <= 2'b00;
            data_q   <= 16'h0000;
            result_q <= 16'h0000;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cmd_q    <= cmd_d;
            data_q   <= data_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cmd_d         = cmd_q;
        data_d        = data_q;
        result_d      = result_q;
        done_d        = 1'b0;
        regsel_raw    = 3'b000;
        cs_raw        = 1'b0;
        wr_raw        = 1'b0;
        arf_funsel_o  = FS_DEC;
        arf_outdsel_o = 2'b00;
        arf_i_o       = 16'h0000;
        mem_data_o    = 8'h00;
        case (state_q)
            IDLE: begin
                if (cmd_if.cmd_valid) begin
                    cmd_d  = cmd_if.cmd;
                    data_d = cmd_if.data_in;
                    case (cmd_if.cmd)
                        2'b00:   state_d = F_LO;
                        2'b01:   state_d = PU_DEC;
                        2'b10:   state_d = PO_LO;
                        default: state_d = JMP;
                    endcase
                end
            end
            F_LO, F_HI: begin
                cs_raw       = 1'b1;
                arf_funsel_o = FS_INC;
                regsel_raw   = SEL_PC;
                if (state_q == F_LO) begin
                    result_d[7:0] = mem_out_i;
                    state_d       = F_HI;
                end else begin
                    result_d[15:8] = mem_out_i;
                    state_d        = IDLE;
                    done_d         = 1'b1;
                end
            end
            PU_DEC: begin
                regsel_raw = SEL_SP;
                state_d    = PU_HI;
            end
            // Second decrement rides along with the high-byte write, which still sees SP0-1.
            PU_HI: begin
                arf_outdsel_o = 2'b01;
                cs_raw        = 1'b1;
                wr_raw        = 1'b1;
                mem_data_o    = data_q[15:8];
                regsel_raw    = SEL_SP;
                state_d       = PU_LO;
            end
            PU_LO: begin
                arf_outdsel_o = 2'b01;
                cs_raw        = 1'b1;
                wr_raw        = 1'b1;
                mem_data_o    = data_q[7:0];
                state_d       = IDLE;
                done_d        = 1'b1;
            end
            PO_LO, PO_HI: begin
                arf_outdsel_o = 2'b01;
                cs_raw        = 1'b1;
                arf_funsel_o  = FS_INC;
                regsel_raw    = SEL_SP;
                if (state_q == PO_LO) begin
                    result_d[7:0] = mem_out_i;
                    state_d       = PO_HI;
                end else begin
                    result_d[15:8] = mem_out_i;
                    state_d        = IDLE;
                    done_d         = 1'b1;
                end
            end
            JMP: begin
                arf_i_o      = data_q;
                arf_funsel_o = FS_LOAD;
                regsel_raw   = SEL_PC;
                state_d      = IDLE;
                done_d       = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // Gate every side-effecting strobe so a reset cycle never touches the ARF or memory.
    assign arf_regsel_o     = rst_i ? 3'b000 : regsel_raw;
    assign mem_cs_o         = cs_raw & ~rst_i;
    assign mem_wr_o         = wr_raw & ~rst_i;
    assign cmd_if.cmd_ready = (state_q == IDLE) && !rst_i;
    assign cmd_if.result    = result_q;
    assign cmd_if.done      = done_q;

endmodule

// File: tb/tb_arf_stack_fetch_ctrl.sv
// tb/tb_arf_stack_fetch_ctrl.sv - scoreboard bench with ARF/memory environment and command-level model
module tb_arf_stack_fetch_ctrl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    arf_stack_fetch_ctrl_if bus();

    logic [15:0] arf_i;
    logic [1:0]  funsel, outdsel;
    logic [2:0]  regsel;
    logic        mem_cs, mem_wr;
    logic [7:0]  mem_data, mem_out;

    arf_stack_fetch_ctrl dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .cmd_if        (bus.slave),
        .mem_out_i     (mem_out),
        .arf_i_o       (arf_i),
        .arf_funsel_o  (funsel),
        .arf_regsel_o  (regsel),
        .arf_outdsel_o (outdsel),
        .mem_cs_o      (mem_cs),
        .mem_wr_o      (mem_wr),
        .mem_data_o    (mem_data)
    );

    // Environment: register file and byte memory
    logic [15:0] pc, sp, ar, addr;
    logic [7:0]  mem [65536];
    logic        init_mem = 1'b0, poke_en = 1'b0, set_en = 1'b0;
    logic [15:0] poke_addr = 16'h0, set_pc = 16'h0, set_sp = 16'h0;
    logic [7:0]  poke_val = 8'h0;

    function automatic logic [7:0] init_byte(input logic [15:0] a);
        return a[7:0] ^ (a[15:8] * 8'h3b) ^ 8'h5a;
    endfunction

    function automatic logic [15:0] arf_f(input logic [15:0] v, input logic [1:0] fs, input logic [15:0] ld);
        case (fs)
            2'b00:   return v - 16'd1;
            2'b01:   return v + 16'd1;
            2'b10:   return ld;
            default: return 16'h0000;
        endcase
    endfunction

    assign addr    = (outdsel == 2'b00) ? pc : (outdsel == 2'b01) ? sp : ar;
    assign mem_out = mem[addr];

    always @(posedge clk) begin
        if (init_mem) begin
            for (int i = 0; i < 65536; i++) mem[i] <= init_byte(16'(i));
        end else if (poke_en) begin
            mem[poke_addr] <= poke_val;
        end else if (mem_cs && mem_wr) begin
            mem[addr] <= mem_data;
        end
        if (set_en) begin
            pc <= set_pc;
            sp <= set_sp;
            ar <= 16'h0000;
        end else begin
            if (regsel[2]) pc <= arf_f(pc, funsel, arf_i);
            if (regsel[1]) sp <= arf_f(sp, funsel, arf_i);
            if (regsel[0]) ar <= arf_f(ar, funsel, arf_i);
        end
    end

    // Command-level reference model
    logic [7:0]  ref_mem [65536];
    logic [15:0] ref_pc, ref_sp, ref_result;

    typedef struct {
        logic [15:0] res, pc, sp, a0, a1;
        logic [7:0]  b0, b1;
        longint      t;
        int          lat;
    } exp_t;

    typedef struct {
        logic        timeout;
        logic [15:0] res, pc, sp, a;
        logic [7:0]  b;
    } chk_t;

    exp_t q[$];
    chk_t cq[$];
    int   nchk = 0, nfail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops expectations when Done is seen, plus immediate state checks
    initial begin
        exp_t e;
        chk_t c;
        logic prev_done = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                chk("rst_ready",  32'(bus.cmd_ready), 32'd0);
                chk("rst_cs",     32'(mem_cs),        32'd0);
                chk("rst_wr",     32'(mem_wr),        32'd0);
                chk("rst_regsel", 32'(regsel),        32'd0);
            end else begin
                if (bus.done) begin
                    chk("done_width", 32'(prev_done), 32'd0);
                    if (q.size() == 0) begin
                        nchk++;
                        nfail++;
                        $display("FAIL unexpected_done: got done=1 expected no pending command at %0t", $time);
                    end else begin
                        e = q.pop_front();
                        chk("result",  32'(bus.result), 32'(e.res));
                        chk("pc",      32'(pc),         32'(e.pc));
                        chk("sp",      32'(sp),         32'(e.sp));
                        chk("mem_a0",  32'(mem[e.a0]),  32'(e.b0));
                        chk("mem_a1",  32'(mem[e.a1]),  32'(e.b1));
                        chk("latency", 32'($time - e.t), 32'((e.lat - 1) * 10 + 5));
                    end
                end
                if (q.size() != 0) chk("busy_ready", 32'(bus.cmd_ready), 32'd0);
                if (cq.size() != 0) begin
                    c = cq.pop_front();
                    if (c.timeout) begin
                        nchk++;
                        nfail++;
                        $display("FAIL timeout: got no ready/done within bound expected progress at %0t", $time);
                    end else begin
                        chk("st_result", 32'(bus.result),    32'(c.res));
                        chk("st_pc",     32'(pc),            32'(c.pc));
                        chk("st_sp",     32'(sp),            32'(c.sp));
                        chk("st_mem",    32'(mem[c.a]),      32'(c.b));
                        chk("st_ready",  32'(bus.cmd_ready), 32'd1);
                        chk("st_done",   32'(bus.done),      32'd0);
                    end
                end
            end
            prev_done = bus.done;
        end
    end

    task automatic push_state(input logic [15:0] a);
        chk_t c;
        c.timeout = 1'b0;
        c.res = ref_result;
        c.pc = ref_pc;
        c.sp = ref_sp;
        c.a = a;
        c.b = ref_mem[a];
        cq.push_back(c);
    endtask

    task automatic push_timeout();
        chk_t c;
        c.timeout = 1'b1;
        c.res = 16'h0; c.pc = 16'h0; c.sp = 16'h0; c.a = 16'h0; c.b = 8'h0;
        cq.push_back(c);
    endtask

    task automatic issue(input logic [1:0] c, input logic [15:0] d);
        exp_t e;
        int n = 0;
        @(negedge clk);
        while (!bus.cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.cmd_ready) begin
            push_timeout();
            return;
        end
        bus.cmd = c;
        bus.data_in = d;
        bus.cmd_valid = 1'b1;
        @(posedge clk);
        e.t = $time;
        case (c)
            2'b00: begin
                e.a0 = ref_pc;
                e.a1 = ref_pc + 16'd1;
                ref_result = {ref_mem[e.a1], ref_mem[e.a0]};
                ref_pc = ref_pc + 16'd2;
                e.lat = 3;
            end
            2'b01: begin
                e.a0 = ref_sp - 16'd1;
                e.a1 = ref_sp - 16'd2;
                ref_mem[e.a0] = d[15:8];
                ref_mem[e.a1] = d[7:0];
                ref_sp = ref_sp - 16'd2;
                e.lat = 4;
            end
            2'b10: begin
                e.a0 = ref_sp;
                e.a1 = ref_sp + 16'd1;
                ref_result = {ref_mem[e.a1], ref_mem[e.a0]};
                ref_sp = ref_sp + 16'd2;
                e.lat = 3;
            end
            default: begin
                e.a0 = ref_pc;
                e.a1 = ref_sp;
                ref_pc = d;
                e.lat = 2;
            end
        endcase
        e.res = ref_result;
        e.pc = ref_pc;
        e.sp = ref_sp;
        e.b0 = ref_mem[e.a0];
        e.b1 = ref_mem[e.a1];
        q.push_back(e);
        // Valid stays high with junk so busy-time commands must be ignored
        #1;
        bus.cmd = 2'($urandom);
        bus.data_in = 16'($urandom);
    endtask

    task automatic release_bus();
        int n = 0;
        @(negedge clk);
        while (!bus.cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        bus.cmd_valid = 1'b0;
        if (!bus.cmd_ready) push_timeout();
    endtask

    task automatic set_regs(input logic [15:0] p, input logic [15:0] s);
        set_pc = p;
        set_sp = s;
        set_en = 1'b1;
        @(posedge clk);
        #1 set_en = 1'b0;
        ref_pc = p;
        ref_sp = s;
    endtask

    task automatic poke(input logic [15:0] a, input logic [7:0] v);
        poke_addr = a;
        poke_val = v;
        poke_en = 1'b1;
        @(posedge clk);
        #1 poke_en = 1'b0;
        ref_mem[a] = v;
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout: got no finish expected end of test");
        $fatal(1, "global timeout");
    end

    initial begin
        int n;
        rst = 1'b1;
        bus.cmd = 2'b00;
        bus.cmd_valid = 1'b0;
        bus.data_in = 16'h0000;
        ref_result = 16'h0000;
        for (int i = 0; i < 65536; i++) ref_mem[i] = init_byte(16'(i));
        init_mem = 1'b1;
        @(posedge clk);
        #1 init_mem = 1'b0;
        set_regs(16'h0010, 16'h0100);
        @(posedge clk);
        #1 rst = 1'b0;
        push_state(16'h0010);

        poke(16'h0010, 8'h34);
        poke(16'h0011, 8'h12);
        issue(2'b00, 16'h0000);
        issue(2'b01, 16'hA5C3);
        issue(2'b10, 16'h0000);
        issue(2'b11, 16'hBEEF);
        issue(2'b00, 16'h0000);
        release_bus();

        set_regs(16'hFFFF, 16'h0000);
        poke(16'hFFFF, 8'hAA);
        poke(16'h0000, 8'h55);
        issue(2'b00, 16'h0000);
        issue(2'b01, 16'h1357);
        issue(2'b10, 16'h0000);
        release_bus();

        for (int k = 0; k < 60; k++) begin
            if (k % 20 == 19) begin
                release_bus();
                set_regs(16'($urandom), 16'($urandom));
            end
            issue(2'($urandom_range(0, 3)), 16'($urandom));
        end
        release_bus();

        // Reset lands while the push is in PU_HI
        set_regs(16'h0400, 16'h0200);
        poke(16'h01FF, 8'h11);
        @(negedge clk);
        bus.cmd = 2'b01;
        bus.data_in = 16'h1122;
        bus.cmd_valid = 1'b1;
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        ref_sp = 16'h01FF;
        ref_result = 16'h0000;
        push_state(16'h01FE);
        push_state(16'h01FF);
        @(negedge clk);

        issue(2'b10, 16'h0000);
        issue(2'b00, 16'h0000);
        release_bus();

        n = 0;
        while ((q.size() != 0 || cq.size() != 0) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) push_timeout();
        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule

// File: doc/arf_stack_fetch_ctrl.md
# arf_stack_fetch_ctrl

Sequencer that drives the control side of the address register file (PC, SP, AR) and the byte-wide memory to execute four 16-bit micro-operations: instruction fetch, stack push, stack pop and PC jump. It issues FunSel/RegSel/OutDSel to the register file, whose OutD drives the memory address directly. It sequences the byte transfers and returns assembled 16-bit results under a valid/ready command handshake.

## Interface
Parameters: none.
- Clock  in  1  single system clock, all state updates on rising edge
- Reset  in  1  synchronous, active-high; returns block to IDLE
- Cmd  in  2  00 FETCH, 01 PUSH, 10 POP, 11 JUMP
- CmdValid  in  1  command request
- CmdReady  out  1  high only in IDLE with Reset low
- DataIn  in  16  push data (PUSH) or jump target (JUMP); sampled at acceptance
- MemOut  in  8  combinational memory read data at address OutD
- ARF_I  out  16  register-file load data
- ARF_FunSel  out  2  00 decrement, 01 increment, 10 load, 11 clear
- ARF_RegSel  out  3  active-high enables: bit2 PC, bit1 SP, bit0 AR
- ARF_OutDSel  out  2  00 PC, 01 SP, 10 AR; this block uses only 00 and 01
- MemCS  out  1  memory access enable, active-high
- MemWR  out  1  1 write, 0 read (valid only with MemCS)
- MemData  out  8  memory write byte
- Result  out  16  FETCH/POP result, held until next FETCH/POP completes
- Done  out  1  one-cycle pulse after the last work cycle of any command

## Operation
- Acceptance: edge where state is IDLE, CmdValid=1 and CmdReady=1. Cmd and DataIn are latched into internal registers at that edge. The block never samples them again for that command.
- States: IDLE, F_LO, F_HI, PU_DEC, PU_HI, PU_LO, PO_LO, PO_HI, JMP.
- IDLE: RegSel=000, MemCS=0, MemWR=0, ARF_I=0, MemData=0, OutDSel=00.
- FETCH: IDLE→F_LO→F_HI→IDLE. Each state drives OutDSel=00, MemCS=1, MemWR=0, FunSel=01, RegSel=100.
  - F_LO edge: Result[7:0]←MemOut.
  - F_HI edge: Result[15:8]←MemOut.
  - Net effect: little-endian word at old PC; PC+=2.
- PUSH: IDLE→PU_DEC→PU_HI→PU_LO→IDLE. The stack grows downward and SP points at the last written byte.
  - PU_DEC: FunSel=00, RegSel=010, MemCS=0.
  - PU_HI: OutDSel=01, MemCS=1, MemWR=1, MemData=data[15:8], FunSel=00, RegSel=010. The write uses the pre-edge SP.
  - PU_LO: OutDSel=01, MemCS=1, MemWR=1, MemData=data[7:0], RegSel=000.
  - Net effect: M[SP0-1]=hi, M[SP0-2]=lo, SP=SP0-2.
- POP: IDLE→PO_LO→PO_HI→IDLE. Each state drives OutDSel=01, MemCS=1, MemWR=0, FunSel=01, RegSel=010.
  - PO_LO edge: Result[7:0]←MemOut.
  - PO_HI edge: Result[15:8]←MemOut.
  - Net effect: SP+=2.
- JUMP: IDLE→JMP→IDLE. JMP drives ARF_I=data, FunSel=10, RegSel=100, MemCS=0.
- Done is registered. It is set on the edge leaving the final work state and cleared on the next edge.
- Commands presented while busy are not accepted. CmdValid may stay high; the request is accepted in the Done cycle, since that cycle is IDLE.
- Arithmetic wrap-around, for example PC FFFF→0000 or SP 0000→FFFF, is performed by the register file. This block applies no special handling; addresses wrap modulo 2^16.

## Timing
- Reset values: state IDLE, Result=0000, Done=0, latched cmd/data=0. CmdReady=0 while Reset=1.
- While Reset=1, RegSel=000, MemCS=0 and MemWR=0 regardless of state. Outputs are gated combinationally, so no register or memory is modified in a reset cycle.
- Reset mid-operation: the command is aborted with no Done. Partial effects already committed are kept, for example PC+1 after F_LO or a high byte already pushed.
- Latency in edges from acceptance to Done rising: FETCH 3, PUSH 4, POP 3, JUMP 2.
- Back-to-back throughput: one command per (work cycles + 1).
- Result changes only on F_LO/F_HI/PO_LO/PO_HI edges. Result is stable while Done=1.

## Test plan
- FETCH, PC=0010, M[0010]=34, M[0011]=12 → Result=1234, PC=0012, Done for exactly one cycle, 3 edges after acceptance.
- PUSH A5C3, SP=0100 → M[00FF]=A5, M[00FE]=C3, SP=00FE, Done after 4 edges. Then POP → Result=A5C3, SP=0100.
- JUMP with DataIn=BEEF, then FETCH → PC=BEEF during fetch, PC=BEF1 after.
- Wrap-around, PC=FFFF, M[FFFF]=AA, M[0000]=55 → Result=55AA, PC=0001.
- CmdValid held high with Cmd changed mid-operation → new Cmd ignored until the IDLE/Done cycle, then accepted. CmdReady=0 throughout busy states.
- Reset asserted during PU_HI of push 1122, SP=0200 → no MemCS/RegSel in reset cycle, SP=01FF, M[01FF]=11, no Done, state IDLE, Result=0000.
